// File: rtl/vga_capture.sv
// VGA 640x480@60 capture: locks onto hs/vs timing and streams active pixels to a pixel RAM.
// Optional error counter enabled with macro VGA_CAPTURE_ERRCNT_EN.
module vga_capture (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        we,
  output logic [8:0]  wr_row,
  output logic [9:0]  wr_col,
  output logic [11:0] wr_data,
  output logic        locked,
  output logic        frame_done,
  output logic        sync_err,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {UNLOCKED, WAIT_VS, LOCKED} state_t;

  state_t      state_reg, state_next;
  logic        hs_s1_reg, vs_s1_reg, hs_prev_reg, vs_at_fall_reg;
  logic [3:0]  r_s1_reg, g_s1_reg, b_s1_reg;
  logic [9:0]  hcnt_reg, hcnt_next, vcnt_reg, vcnt_next;
  logic        good_cnt_reg, good_cnt_next;
  logic        we_reg, we_next, frame_done_reg, frame_done_next, sync_err_reg;
  logic [8:0]  wr_row_reg;
  logic [9:0]  wr_col_reg, row_calc, col_calc;
  logic [11:0] wr_data_reg;
  logic        hs_fall, vs_reset, hwrap, line_bad, frame_bad, wrap_err, err_now, active;

  // hcnt_next/vcnt_next are the position of the pixel currently held in S1
  always_comb begin
    hs_fall   = hs_prev_reg & ~hs_s1_reg;
    vs_reset  = hs_fall & ~vs_s1_reg & vs_at_fall_reg;
    hwrap     = ~hs_fall & (hcnt_reg == 10'd799);
    line_bad  = hs_fall & (hcnt_reg != 10'd799);
    frame_bad = vs_reset & (vcnt_reg != 10'd524);
    wrap_err  = hwrap & (state_reg == LOCKED);
    err_now   = line_bad | frame_bad | wrap_err;
    hcnt_next = (hs_fall | hwrap) ? 10'd0 : hcnt_reg + 10'd1;
    if (vs_reset)
      vcnt_next = 10'd0;
    else if (hs_fall)
      vcnt_next = vcnt_reg + 10'd1;
    else
      vcnt_next = vcnt_reg;
    active   = (hcnt_next >= 10'd144) && (hcnt_next <= 10'd783) &&
               (vcnt_next >= 10'd35)  && (vcnt_next <= 10'd514);
    row_calc = vcnt_next - 10'd35;
    col_calc = hcnt_next - 10'd144;
    // an error on the same cycle as a pixel suppresses the write
    we_next         = (state_reg == LOCKED) & active & ~err_now;
    frame_done_next = we_reg & (wr_row_reg == 9'd479) & (wr_col_reg == 10'd639);
  end

  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    if (line_bad | frame_bad) begin
      state_next    = UNLOCKED;
      good_cnt_next = 1'b0;
    end else begin
      case (state_reg)
        UNLOCKED: begin
          if (hs_fall) begin
            if (good_cnt_reg) begin
              state_next    = WAIT_VS;
              good_cnt_next = 1'b0;
            end else begin
              good_cnt_next = 1'b1;
            end
          end
        end
        WAIT_VS: begin
          if (vs_reset)
            state_next = LOCKED;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      state_reg      <= UNLOCKED;
      hs_s1_reg      <= 1'b0;
      vs_s1_reg      <= 1'b0;
      r_s1_reg       <= 4'd0;
      g_s1_reg       <= 4'd0;
      b_s1_reg       <= 4'd0;
      hs_prev_reg    <= 1'b0;
      vs_at_fall_reg <= 1'b0;
      hcnt_reg       <= 10'd0;
      vcnt_reg       <= 10'd0;
      good_cnt_reg   <= 1'b0;
      we_reg         <= 1'b0;
      wr_row_reg     <= 9'd0;
      wr_col_reg     <= 10'd0;
      wr_data_reg    <= 12'd0;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hs_s1_reg      <= hs;
      vs_s1_reg      <= vs;
      r_s1_reg       <= r;
      g_s1_reg       <= g;
      b_s1_reg       <= b;
      hs_prev_reg    <= hs_s1_reg;
      if (hs_fall)
        vs_at_fall_reg <= vs_s1_reg;
      hcnt_reg       <= hcnt_next;
      vcnt_reg       <= vcnt_next;
      good_cnt_reg   <= good_cnt_next;
      we_reg         <= we_next;
      if (we_next) begin
        wr_row_reg  <= row_calc[8:0];
        wr_col_reg  <= col_calc;
        wr_data_reg <= {b_s1_reg, g_s1_reg, r_s1_reg};
      end
      frame_done_reg <= frame_done_next;
      sync_err_reg   <= err_now;
    end
  end

`ifdef VGA_CAPTURE_ERRCNT_EN
  logic [15:0] err_cnt_reg;

  always_ff @(posedge vga_clk) begin
    if (!clrn)
      err_cnt_reg <= 16'd0;
    else if (err_now && (err_cnt_reg != 16'hFFFF))
      err_cnt_reg <= err_cnt_reg + 16'd1;
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = 16'd0;
`endif

  assign we         = we_reg;
  assign wr_row     = wr_row_reg;
  assign wr_col     = wr_col_reg;
  assign wr_data    = wr_data_reg;
  assign locked     = (state_reg == LOCKED);
  assign frame_done = frame_done_reg;
  assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_vga_capture.sv
// Frame-table driven bench for vga_capture: streams 800x525 frames, scoreboards every pixel write.
module tb_vga_capture;

  logic        vga_clk = 1'b0;
  logic        clrn, hs, vs;
  logic [3:0]  r, g, b;
  logic        we, locked, frame_done, sync_err;
  logic [8:0]  wr_row;
  logic [9:0]  wr_col;
  logic [11:0] wr_data;
  logic [15:0] err_cnt;

  vga_capture dut (
    .vga_clk(vga_clk), .clrn(clrn), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .we(we), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .locked(locked), .frame_done(frame_done), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #20 vga_clk = ~vga_clk;

  // per-frame stimulus and expectations; -1 means "don't care"
  typedef struct {
    int n_lines;
    int short_line;
    int rst_line;
    int chk;
    int last_row;
    int last_col;
    int exp_we;
    int exp_fd;
    int exp_se;
    int exp_lock;
  } frame_t;

  typedef struct {
    logic [8:0]  row;
    logic [9:0]  col;
    logic [11:0] data;
  } pix_t;

  frame_t tbl[10];
  pix_t   exp_q[$];
  pix_t   e;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_frame = 0;
  int chk_mode  = 0;
  int cyc = 0;
  int t00 = -1;
  int we_cnt[12];
  int fd_cnt[12];
  int se_cnt[12];
  int err6 = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, frame %0d)", name, act, req, cyc, cur_frame);
    end
  endtask

  always @(posedge vga_clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge vga_clk);
      if (cur_frame > 0) begin
        if (we) we_cnt[cur_frame]++;
        if (frame_done) fd_cnt[cur_frame]++;
        if (sync_err) se_cnt[cur_frame]++;
      end
      if (we && chk_mode != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", we, 0);
        end else begin
          e = exp_q.pop_front();
          check("pixel_row_col_data", {wr_row, wr_col, wr_data}, {e.row, e.col, e.data});
          if (cur_frame == 3 && e.row == 9'd0 && e.col == 10'd0 && t00 >= 0) begin
            check("latency_pix00", cyc - t00, 2);
            $display("pixel(0,0) frame 3: wr_data=0x%0h we at cycle %0d, pins at cycle %0d", wr_data, cyc, t00);
          end
        end
      end
    end
  end

  int len, row, col;
  logic [11:0] pd;
  logic [8:0]  prow;
  logic [9:0]  pcol;

  initial begin
    tbl[0] = '{525, -1,  -1, 0,  -1,  -1,     -1, -1, -1, -1};
    tbl[1] = '{525, -1,  -1, 0,  -1,  -1,     -1, -1, -1, -1};
    tbl[2] = '{525, -1,  -1, 1, 479, 639, 307200,  1,  0,  1};
    tbl[3] = '{525, -1,  -1, 1, 479, 639, 307200,  1,  0,  1};
    tbl[4] = '{525, 100, -1, 1,  65, 639,  42240,  0,  1,  1};
    tbl[5] = '{524, -1,  -1, 1, 479, 639, 307200,  1,  0,  1};
    tbl[6] = '{525, -1,  -1, 1,  -1,  -1,      0,  0,  1,  0};
    tbl[7] = '{525, -1, 235, 1, 200, 298, 128299,  0, -1,  1};
    tbl[8] = '{525, -1,  -1, 0,  -1,  -1,     -1, -1, -1, -1};
    tbl[9] = '{525, -1,  -1, 1, 479, 639, 307200,  1,  0,  1};

    clrn = 1'b0; hs = 1'b1; vs = 1'b1; r = 4'd0; g = 4'd0; b = 4'd0;
    repeat (4) @(posedge vga_clk);
    @(negedge vga_clk);
    check("reset_we", we, 0);
    check("reset_locked", locked, 0);
    check("reset_pulses", {frame_done, sync_err}, 0);
    check("reset_wr_bus", {wr_row, wr_col, wr_data}, 0);
    check("reset_err_cnt", err_cnt, 0);
    $display("reset: we=%0d locked=%0d err_cnt=%0d", we, locked, err_cnt);
    @(posedge vga_clk); #1;
    clrn = 1'b1;

    for (int f = 0; f < 10; f++) begin
      cur_frame = f + 1;
      chk_mode  = tbl[f].chk;
      for (int ln = 0; ln < tbl[f].n_lines; ln++) begin
        len = (ln == tbl[f].short_line) ? 799 : 800;
        for (int x = 0; x < len; x++) begin
          @(posedge vga_clk); #1;
          if (ln == tbl[f].rst_line && x == 445) begin
            check("midreset_we", we, 0);
            check("midreset_locked", locked, 0);
            check("midreset_pulses", {frame_done, sync_err}, 0);
            check("midreset_wr_bus", {wr_row, wr_col, wr_data}, 0);
            check("midreset_err_cnt", err_cnt, 0);
            $display("mid-frame reset frame %0d: we=%0d locked=%0d", cur_frame, we, locked);
            clrn = 1'b1;
          end
          if (x == 0 && ln == 10) begin
            if (tbl[f].exp_lock >= 0) check("locked_line10", locked, tbl[f].exp_lock);
            if (f == 5) err6 = err_cnt;
            if (f == 6) begin
`ifdef VGA_CAPTURE_ERRCNT_EN
              check("err_cnt_short_frame", err_cnt - err6, 1);
`else
              check("err_cnt_short_frame", err_cnt, 0);
`endif
            end
          end
          if (f == 4 && ln == 110 && x == 0) check("locked_after_short_line", locked, 0);
          hs = (x >= 96);
          vs = (ln >= 2);
          if (ln >= 35 && ln <= 514 && x >= 144 && x <= 783) begin
            row  = ln - 35;
            col  = x - 144;
            prow = 9'(row);
            pcol = 10'(col);
            pd   = (row == 0 && col == 0) ? 12'hA53 : 12'(row * 7 + col * 13 + f * 5);
            {b, g, r} = pd;
            if (tbl[f].chk != 0 &&
                (row < tbl[f].last_row || (row == tbl[f].last_row && col <= tbl[f].last_col)))
              exp_q.push_back('{prow, pcol, pd});
            if (f == 2 && row == 0 && col == 0) t00 = cyc;
          end else begin
            {b, g, r} = 12'($urandom);
          end
          if (ln == tbl[f].rst_line && x == 444) clrn = 1'b0;
        end
      end
      $display("frame %0d: we=%0d frame_done=%0d sync_err=%0d locked=%0d err_cnt=%0d",
               cur_frame, we_cnt[cur_frame], fd_cnt[cur_frame], se_cnt[cur_frame], locked, err_cnt);
      if (tbl[f].exp_we >= 0) check("we_count", we_cnt[cur_frame], tbl[f].exp_we);
      if (tbl[f].exp_fd >= 0) check("frame_done_count", fd_cnt[cur_frame], tbl[f].exp_fd);
      if (tbl[f].exp_se >= 0) check("sync_err_count", se_cnt[cur_frame], tbl[f].exp_se);
      if (tbl[f].chk != 0) begin
        check("missing_writes", exp_q.size(), 0);
        exp_q.delete();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
